block_loader: RTL and testbench

- Consumer of the block sequencer's `block_ready` index stream in the game datapath.
- Each new nonzero index (1..NUM_BLOCKS) is queued. The matching 4x4 shape bitmap is then read row-by-row from an internal ROM and delivered to the draw engine over a valid/ack handshake.
- Signals `all_loaded` once the last block's final row has been accepted.

---
 rtl/block_pkg.sv | 27 ++
 rtl/block_rom.sv | 15 +
 rtl/block_loader.sv | 141 ++++++++++++++
 tb/tb_block_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared types, sizes and the shape bitmap table for the block loader datapath.
package block_pkg;

    localparam int NUM_BLOCKS = 5;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int QDEPTH     = 8;
    localparam int QAW        = $clog2(QDEPTH);

    typedef logic [2:0]      block_id_t;
    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    // Bit COLS-1 is the leftmost cell; unused indexes 0, 6 and 7 read as empty.
    localparam row_t SHAPES [0:7][0:ROWS-1] = '{
        '{4'b0000, 4'b0000, 4'b0000, 4'b0000},
        '{4'b0110, 4'b0110, 4'b0000, 4'b0000},
        '{4'b1111, 4'b0000, 4'b0000, 4'b0000},
        '{4'b1110, 4'b0100, 4'b0000, 4'b0000},
        '{4'b1000, 4'b1000, 4'b1100, 4'b0000},
        '{4'b1100, 4'b0110, 4'b0000, 4'b0000},
        '{4'b0000, 4'b0000, 4'b0000, 4'b0000},
        '{4'b0000, 4'b0000, 4'b0000, 4'b0000}
    };

endpackage

// File: rtl/block_rom.sv
// Synchronous shape ROM: one row bitmap per {id,row} address, one cycle of latency.
module block_rom
    import block_pkg::*;
(
    input  logic             Clk,
    input  logic [2:0]       id,
    input  logic [1:0]       row,
    output logic [COLS-1:0]  data
);

    always_ff @(posedge Clk) begin
        data <= SHAPES[id][row];
    end

endmodule

// File: rtl/block_loader.sv
// Queues new block indexes from the sequencer and streams each shape row-by-row
// to the draw engine over a valid/ack handshake.
module block_loader
    import block_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [2:0]       block_ready,
    output logic             shape_valid,
    input  logic             shape_ack,
    output logic [2:0]       shape_id,
    output logic [1:0]       row_idx,
    output logic [COLS-1:0]  shape_row,
    output logic             shape_last,
    output logic             all_loaded,
    output logic             overrun
);

    block_id_t        prev_idx_reg;
    block_id_t        q_mem [0:QDEPTH-1];
    logic [QAW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [QAW:0]     count_reg;
    logic             overrun_reg;

    state_t           state_reg, state_next;
    block_id_t        cur_id_reg, cur_id_next;
    logic [1:0]       row_reg, row_next;
    logic             all_loaded_reg, all_loaded_next;
    row_t             rom_data;

    logic q_empty, q_full, push_req, push_ok, pop;

    assign q_empty  = (count_reg == '0);
    assign q_full   = (count_reg == (QAW+1)'(QDEPTH));
    assign push_req = (block_ready != prev_idx_reg) && (block_ready != 3'd0)
                      && (block_ready <= 3'(NUM_BLOCKS));
    assign pop      = (state_reg == IDLE) && !q_empty;
    // A full queue still accepts a push when an entry leaves on the same edge.
    assign push_ok  = push_req && (!q_full || pop);

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            q_mem[wr_ptr_reg] <= block_ready;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_idx_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            prev_idx_reg <= block_ready;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + QAW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + QAW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push_ok) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= IDLE;
            cur_id_reg     <= '0;
            row_reg        <= '0;
            all_loaded_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_id_reg     <= cur_id_next;
            row_reg        <= row_next;
            all_loaded_reg <= all_loaded_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_id_next     = cur_id_reg;
        row_next        = row_reg;
        all_loaded_next = all_loaded_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    cur_id_next = q_mem[rd_ptr_reg];
                    row_next    = '0;
                    state_next  = FETCH;
                end
            end
            FETCH: state_next = SEND;
            SEND: begin
                if (shape_ack) begin
                    if (row_reg != 2'(ROWS-1)) begin
                        row_next   = row_reg + 2'd1;
                        state_next = FETCH;
                    end else if (cur_id_reg == 3'(NUM_BLOCKS)) begin
                        all_loaded_next = 1'b1;
                        state_next      = DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                // Sequencer returning to 0 marks a new round; buffered entries resume.
                if (block_ready == 3'd0) begin
                    all_loaded_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address stays put through SEND, so the ROM output holds until ack.
    block_rom u_rom (
        .Clk  (Clk),
        .id   (cur_id_reg),
        .row  (row_reg),
        .data (rom_data)
    );

    assign shape_valid = (state_reg == SEND);
    assign shape_id    = shape_valid ? cur_id_reg : 3'd0;
    assign row_idx     = shape_valid ? row_reg : 2'd0;
    assign shape_row   = shape_valid ? rom_data : '0;
    assign shape_last  = shape_valid && (row_reg == 2'(ROWS-1));
    assign all_loaded  = all_loaded_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_block_loader.sv
// Self-checking bench for block_loader: transaction-level reference model plus directed and random stimulus.
module tb_block_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] block_ready = 3'd0;
    logic       shape_ack = 1'b0;
    logic       shape_valid;
    logic [2:0] shape_id;
    logic [1:0] row_idx;
    logic [3:0] shape_row;
    logic       shape_last;
    logic       all_loaded;
    logic       overrun;

    int total = 0;
    int bad = 0;

    block_loader dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .block_ready (block_ready),
        .shape_valid (shape_valid),
        .shape_ack   (shape_ack),
        .shape_id    (shape_id),
        .row_idx     (row_idx),
        .shape_row   (shape_row),
        .shape_last  (shape_last),
        .all_loaded  (all_loaded),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference shapes, written row by row from the shape descriptions.
    logic [3:0] ref_shape [0:7][0:3];
    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++)
                ref_shape[i][j] = 4'b0000;
        ref_shape[1][0] = 4'b0110; ref_shape[1][1] = 4'b0110;
        ref_shape[2][0] = 4'b1111;
        ref_shape[3][0] = 4'b1110; ref_shape[3][1] = 4'b0100;
        ref_shape[4][0] = 4'b1000; ref_shape[4][1] = 4'b1000; ref_shape[4][2] = 4'b1100;
        ref_shape[5][0] = 4'b1100; ref_shape[5][1] = 4'b0110;
    end

    typedef struct {
        int         id;
        int         row;
        logic [3:0] bits;
        bit         last;
    } rec_t;

    // Model: busy 0 = waiting for work, 1 = serving a shape, 2 = finished round.
    // While serving, step s runs 0..7: even steps fetch, odd steps offer row s/2.
    int   m_busy = 0;
    int   m_s = 0;
    int   m_id = 0;
    int   m_prev = 0;
    bit   m_all = 0;
    bit   m_ovr = 0;
    int   mq[$];
    rec_t log_q[$];

    always @(posedge clk or negedge rst_n) begin
        int   br;
        bit   offer, took, push, pop;
        int   head;
        rec_t r;
        if (!rst_n) begin
            m_busy = 0; m_s = 0; m_id = 0; m_prev = 0; m_all = 0; m_ovr = 0;
            mq.delete();
        end else begin
            br    = int'(block_ready);
            offer = (m_busy == 1) && (m_s % 2 == 1);
            took  = offer && shape_ack;
            push  = (br != m_prev) && (br >= 1) && (br <= 5);
            pop   = (m_busy == 0) && (mq.size() > 0);
            head  = 0;
            if (pop) head = mq.pop_front();
            if (push) begin
                if (mq.size() < 8) mq.push_back(br);
                else m_ovr = 1;
            end
            if (pop) begin
                m_id = head; m_s = 0; m_busy = 1;
            end else if (m_busy == 1) begin
                if (m_s % 2 == 0) begin
                    m_s++;
                end else if (took) begin
                    r.id = m_id; r.row = m_s / 2; r.bits = ref_shape[m_id][m_s / 2]; r.last = (m_s == 7);
                    log_q.push_back(r);
                    if (m_s == 7) begin
                        if (m_id == 5) begin m_all = 1; m_busy = 2; end
                        else m_busy = 0;
                    end else begin
                        m_s++;
                    end
                end
            end else if (m_busy == 2 && br == 0) begin
                m_all = 0; m_busy = 0;
            end
            m_prev = br;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        ev = (m_busy == 1) && (m_s % 2 == 1);
        chk("valid", int'(shape_valid), int'(ev));
        if (ev) begin
            chk("shape_id", int'(shape_id), m_id);
            chk("row_idx", int'(row_idx), m_s / 2);
            chk("shape_row", int'(shape_row), int'(ref_shape[m_id][m_s / 2]));
            chk("shape_last", int'(shape_last), int'(m_s == 7));
        end
        chk("all_loaded", int'(all_loaded), int'(m_all));
        chk("overrun", int'(overrun), int'(m_ovr));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        block_ready = 3'd0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        cyc();
        chk("reset valid", int'(shape_valid), 0);
        chk("reset row", int'(shape_row), 0);
        chk("reset all_loaded", int'(all_loaded), 0);
        chk("reset overrun", int'(overrun), 0);
        cyc();
        rst_n = 1'b1;

        // Round of all five blocks with ack tied high.
        shape_ack = 1'b1;
        base = log_q.size();
        cyc();
        for (int k = 1; k <= 5; k++) begin
            block_ready = 3'(k);
            cyc();
        end
        for (int i = 0; i < 200 && !all_loaded; i++) cyc();
        chk("all_loaded rise", int'(all_loaded), 1);
        chk("round row count", log_q.size() - base, 20);
        for (int k = 0; k < 5; k++) chk("round order", log_q[base + 4 * k].id, k + 1);
        chk("blk3 row0", int'(log_q[base + 8].bits), 4'b1110);
        chk("blk3 row1", int'(log_q[base + 9].bits), 4'b0100);
        chk("blk3 row2", int'(log_q[base + 10].bits), 4'b0000);
        chk("blk3 row3", int'(log_q[base + 11].bits), 4'b0000);
        chk("round overrun", int'(overrun), 0);

        // Sequencer restart out of the finished round.
        block_ready = 3'd5;
        cyc();
        block_ready = 3'd0;
        cyc();
        chk("all_loaded clear", int'(all_loaded), 0);
        base = log_q.size();
        block_ready = 3'd1;
        repeat (20) cyc();
        chk("restart rows", log_q.size() - base, 4);
        chk("restart id", log_q[log_q.size() - 1].id, 1);

        // A held index yields a single shape.
        base = log_q.size();
        block_ready = 3'd2;
        repeat (50) cyc();
        chk("held rows", log_q.size() - base, 4);
        chk("held row0", int'(log_q[base].bits), 4'b1111);
        chk("held row1", int'(log_q[base + 1].bits), 4'b0000);
        for (int j = 0; j < 4; j++) chk("held last", int'(log_q[base + j].last), int'(j == 3));

        // Ack withheld: outputs must hold steady.
        shape_ack = 1'b0;
        block_ready = 3'd1;
        for (int i = 0; i < 10 && !shape_valid; i++) cyc();
        chk("stall valid seen", int'(shape_valid), 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall valid", int'(shape_valid), 1);
            chk("stall id", int'(shape_id), 1);
            chk("stall row", int'(row_idx), 0);
            chk("stall bits", int'(shape_row), 4'b0110);
        end
        shape_ack = 1'b1;
        cyc();
        chk("bubble after ack", int'(shape_valid), 0);
        repeat (20) cyc();

        // Overfill the queue while the loader is stalled.
        reset_pulse();
        shape_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            block_ready = (i % 2 == 0) ? 3'd1 : 3'd2;
            cyc();
        end
        chk("overrun set", int'(overrun), 1);
        base = log_q.size();
        shape_ack = 1'b1;
        repeat (120) cyc();
        chk("overfill rows", log_q.size() - base, 36);
        chk("overrun sticky", int'(overrun), 1);

        // Randomised traffic.
        reset_pulse();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) block_ready = 3'($urandom_range(0, 7));
            shape_ack = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset asserted mid-shape.
        reset_pulse();
        shape_ack = 1'b1;
        block_ready = 3'd4;
        for (int i = 0; i < 60 && !(shape_valid && row_idx == 2'd2); i++) cyc();
        chk("blk4 row2 reached", int'(shape_valid && row_idx == 2'd2), 1);
        block_ready = 3'd0;
        rst_n = 1'b0;
        #1;
        chk("async drop valid", int'(shape_valid), 0);
        cyc();
        rst_n = 1'b1;
        repeat (20) cyc();
        chk("quiet after reset", int'(shape_valid), 0);
        base = log_q.size();
        block_ready = 3'd3;
        repeat (30) cyc();
        chk("post-reset rows", log_q.size() - base, 4);
        chk("post-reset id", log_q[log_q.size() - 1].id, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
